opll_bus_writer: RTL and testbench

OPLL_BUS_WRITER -- requirements
Module: opll_bus_writer

---
 rtl/opll_bus_writer_pkg.sv | 38 +++
 rtl/opll_cmd_fifo.sv | 62 ++++++
 rtl/opll_bus_writer.sv | 156 +++++++++++++++
 tb/tb_opll_bus_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opll_bus_writer_pkg.sv
// Shared definitions for the OPLL bus writer.
// Holds the FSM state encoding, the per-chip base addresses for I/O-mapped
// and memory-mapped OPLLs, the default post-handshake wait lengths, and the
// command word layout stored in the command FIFO.
package opll_bus_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_WAIT_A = 3'd2,
      ST_DATA   = 3'd3,
      ST_WAIT_D = 3'd4
   } state_t;

   // Base addresses carry A0=0; the data port is base+1.
   localparam logic [15:0] IO_BASE_CHIP0  = 16'h007C;
   localparam logic [15:0] IO_BASE_CHIP1  = 16'h007A;
   localparam logic [15:0] MEM_BASE_CHIP0 = 16'h7FF4;
   localparam logic [15:0] MEM_BASE_CHIP1 = 16'h7FF2;

   // Waits in clk cycles with clk = 24 x phiM: 12 phiM and 84 phiM.
   localparam int DEFAULT_ADDR_WAIT = 288;
   localparam int DEFAULT_DATA_WAIT = 2016;

   typedef struct packed {
      logic       chip;
      logic [7:0] reg_idx;
      logic [7:0] data;
   } opll_cmd_t;

   localparam int CMD_W = $bits(opll_cmd_t);

   function automatic logic [15:0] base_addr(input logic memmap, input logic chip);
      if (memmap) return chip ? MEM_BASE_CHIP1 : MEM_BASE_CHIP0;
      return chip ? IO_BASE_CHIP1 : IO_BASE_CHIP0;
   endfunction

endpackage

// File: rtl/opll_cmd_fifo.sv
// Synchronous show-ahead command FIFO.
// The head entry is presented on rd_data straight from the storage array;
// full/empty are registered flags recomputed from the next occupancy.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   wr_en/wr_data push request and word (ignored while full)
//   rd_en         pop the head entry (ignored while empty)
//   rd_data       current head entry
//   full, empty   registered occupancy flags
module opll_cmd_fifo #(
   parameter int DATA_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W:0]    count_next;
   logic              push;
   logic              pop;

   assign push = wr_en & ~full;
   assign pop  = rd_en & ~empty;

   assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

   assign rd_data = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         full  <= (count_next == (PTR_W+1)'(FIFO_DEPTH));
         empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/opll_bus_writer.sv
// OPLL (YM2413) register writer for a Z80-style bus.
// Commands (chip, register, value) are queued in a FIFO and each one is
// issued as two bus writes: register index to the address port, then the
// value to the data port, each followed by the idle time the OPLL needs.
// Both chips share one wait timer, so commands never interleave.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_chip, cmd_reg, cmd_data       target chip, register index, value
//   busy                              queue non-empty or a write in flight
//   bus_valid/bus_ready               bus transaction handshake
//   bus_memreq, bus_ioreq, bus_write  request qualifiers (0 when idle)
//   bus_address, bus_wdata            bus address and write data
module opll_bus_writer
   import opll_bus_writer_pkg::*;
#(
   parameter int ADDR_WAIT  = DEFAULT_ADDR_WAIT,
   parameter int DATA_WAIT  = DEFAULT_DATA_WAIT,
   parameter bit USE_MEMMAP = 1'b0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_chip,
   input  logic [7:0]  cmd_reg,
   input  logic [7:0]  cmd_data,
   output logic        busy,
   output logic        bus_memreq,
   output logic        bus_ioreq,
   output logic [15:0] bus_address,
   output logic        bus_write,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [7:0]  bus_wdata
);

   localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   // The counter is loaded on the handshake edge and the phase change
   // happens on the edge where it reads zero, giving exactly N idle cycles.
   localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_WAIT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             rst_done;
   logic             fifo_full;
   logic             fifo_empty;
   opll_cmd_t        cmd_in;
   opll_cmd_t        fifo_head;
   logic             push;
   logic             pop;
   logic             cmd_chip_q;
   logic [7:0]       cmd_data_q;

   assign cmd_in = '{chip: cmd_chip, reg_idx: cmd_reg, data: cmd_data};

   // rst_done keeps cmd_ready low for as long as reset is held.
   assign cmd_ready = rst_done & ~fifo_full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state == ST_IDLE) & ~fifo_empty;
   assign busy      = ~fifo_empty | (state != ST_IDLE);

   opll_cmd_fifo #(
      .DATA_W     (CMD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (push),
      .wr_data (cmd_in),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         rst_done    <= 1'b0;
         bus_valid   <= 1'b0;
         bus_write   <= 1'b0;
         bus_memreq  <= 1'b0;
         bus_ioreq   <= 1'b0;
         bus_address <= 16'h0000;
         bus_wdata   <= 8'h00;
      end else begin
         rst_done <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state       <= ST_ADDR;
                  bus_valid   <= 1'b1;
                  bus_write   <= 1'b1;
                  bus_memreq  <= USE_MEMMAP;
                  bus_ioreq   <= !USE_MEMMAP;
                  bus_address <= base_addr(USE_MEMMAP, fifo_head.chip);
                  bus_wdata   <= fifo_head.reg_idx;
               end
            end
            ST_ADDR: begin
               if (bus_ready) begin
                  state      <= ST_WAIT_A;
                  wait_cnt   <= ADDR_LOAD;
                  bus_valid  <= 1'b0;
                  bus_write  <= 1'b0;
                  bus_memreq <= 1'b0;
                  bus_ioreq  <= 1'b0;
               end
            end
            ST_WAIT_A: begin
               if (wait_cnt == '0) begin
                  state       <= ST_DATA;
                  bus_valid   <= 1'b1;
                  bus_write   <= 1'b1;
                  bus_memreq  <= USE_MEMMAP;
                  bus_ioreq   <= !USE_MEMMAP;
                  bus_address <= base_addr(USE_MEMMAP, cmd_chip_q) | 16'h0001;
                  bus_wdata   <= cmd_data_q;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bus_ready) begin
                  state      <= ST_WAIT_D;
                  wait_cnt   <= DATA_LOAD;
                  bus_valid  <= 1'b0;
                  bus_write  <= 1'b0;
                  bus_memreq <= 1'b0;
                  bus_ioreq  <= 1'b0;
               end
            end
            ST_WAIT_D: begin
               if (wait_cnt == '0) state <= ST_IDLE;
               else                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Chip and value of the popped command, needed again for the data phase.
   always_ff @(posedge clk) begin
      if (pop) begin
         cmd_chip_q <= fifo_head.chip;
         cmd_data_q <= fifo_head.data;
      end
   end

endmodule

// File: tb/tb_opll_bus_writer.sv
module tb_opll_bus_writer;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid   [2];
   logic        cmd_ready   [2];
   logic        cmd_chip    [2];
   logic [7:0]  cmd_reg     [2];
   logic [7:0]  cmd_data    [2];
   logic        busy        [2];
   logic        bus_memreq  [2];
   logic        bus_ioreq   [2];
   logic [15:0] bus_address [2];
   logic        bus_write   [2];
   logic        bus_valid   [2];
   logic        bus_ready   [2] = '{1'b0, 1'b1};
   logic [7:0]  bus_wdata   [2];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   resp_mode = 0;   // 0: ready low, 1: ready held high, 2: ready 5 cycles after valid
   int   vcnt = 0;
   txn_t exp_q    [2][$];
   int   rise_log [2][$];
   int   hs_log   [2][$];
   logic prev_valid [2] = '{1'b0, 1'b0};
   int   run_len    [2] = '{0, 0};

   opll_bus_writer dut0 (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid[0]),
      .cmd_ready   (cmd_ready[0]),
      .cmd_chip    (cmd_chip[0]),
      .cmd_reg     (cmd_reg[0]),
      .cmd_data    (cmd_data[0]),
      .busy        (busy[0]),
      .bus_memreq  (bus_memreq[0]),
      .bus_ioreq   (bus_ioreq[0]),
      .bus_address (bus_address[0]),
      .bus_write   (bus_write[0]),
      .bus_valid   (bus_valid[0]),
      .bus_ready   (bus_ready[0]),
      .bus_wdata   (bus_wdata[0])
   );

   opll_bus_writer #(
      .ADDR_WAIT  (8),
      .DATA_WAIT  (16),
      .USE_MEMMAP (1'b1),
      .FIFO_DEPTH (4)
   ) dut1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid[1]),
      .cmd_ready   (cmd_ready[1]),
      .cmd_chip    (cmd_chip[1]),
      .cmd_reg     (cmd_reg[1]),
      .cmd_data    (cmd_data[1]),
      .busy        (busy[1]),
      .bus_memreq  (bus_memreq[1]),
      .bus_ioreq   (bus_ioreq[1]),
      .bus_address (bus_address[1]),
      .bus_write   (bus_write[1]),
      .bus_valid   (bus_valid[1]),
      .bus_ready   (bus_ready[1]),
      .bus_wdata   (bus_wdata[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_pair(input int d, input logic chip, input logic [7:0] r, input logic [7:0] dt);
      logic [15:0] base;
      if (d == 0) base = chip ? 16'h007A : 16'h007C;
      else        base = chip ? 16'h7FF2 : 16'h7FF4;
      exp_q[d].push_back('{addr: base, wdata: r});
      exp_q[d].push_back('{addr: base | 16'h0001, wdata: dt});
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic push0(input logic chip, input logic [7:0] r, input logic [7:0] dt,
                        input logic exp_acc, input logic exp_pairs);
      cmd_valid[0] = 1'b1;
      cmd_chip[0]  = chip;
      cmd_reg[0]   = r;
      cmd_data[0]  = dt;
      @(negedge clk);
      chk($sformatf("cmd_ready reg %0h", r), cmd_ready[0], exp_acc);
      if (exp_acc && exp_pairs) expect_pair(0, chip, r, dt);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d, input int budget, input string name);
      int n = 0;
      while (busy[d] === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy[d], 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs(input int d);
      rise_log[d].delete();
      hs_log[d].delete();
   endtask

   // Bus responder for dut0; dut1 always sees bus_ready high.
   initial begin : responder
      forever begin
         @(posedge clk);
         #1;
         bus_ready[1] = 1'b1;
         case (resp_mode)
            1: bus_ready[0] = 1'b1;
            2: begin
               if (bus_valid[0] && !bus_ready[0]) begin
                  vcnt++;
                  if (vcnt >= 5) bus_ready[0] = 1'b1;
               end else begin
                  bus_ready[0] = 1'b0;
                  vcnt = 0;
               end
            end
            default: begin
               bus_ready[0] = 1'b0;
               vcnt = 0;
            end
         endcase
      end
   end

   // Monitor: qualifiers every cycle, scoreboard compare on each handshake.
   initial begin : monitor
      txn_t t;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d memreq", d), bus_memreq[d], bus_valid[d] & logic'(d == 1));
            chk($sformatf("dut%0d ioreq", d), bus_ioreq[d], bus_valid[d] & logic'(d == 0));
            if (bus_valid[d] && !prev_valid[d]) rise_log[d].push_back(cyc);
            run_len[d] = bus_valid[d] ? run_len[d] + 1 : 0;
            if (bus_valid[d] && bus_ready[d]) begin
               hs_log[d].push_back(cyc + 1);
               chk($sformatf("dut%0d bus_write", d), bus_write[d], 1'b1);
               if (d == 1) chk("dut1 valid cycles per phase", run_len[d], 1);
               if (exp_q[d].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL dut%0d unexpected txn: got addr %h data %h, required none",
                           d, bus_address[d], bus_wdata[d]);
               end else begin
                  t = exp_q[d].pop_front();
                  chk($sformatf("dut%0d address", d), bus_address[d], t.addr);
                  chk($sformatf("dut%0d wdata", d), bus_wdata[d], t.wdata);
               end
            end
            prev_valid[d] = bus_valid[d];
         end
      end
   end

   initial begin : watchdog
      #700000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      reset_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0;
         cmd_chip[d]  = 1'b0;
         cmd_reg[d]   = 8'h00;
         cmd_data[d]  = 8'h00;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst bus_valid", bus_valid[0], 1'b0);
      chk("rst bus_write", bus_write[0], 1'b0);
      chk("rst bus_address", bus_address[0], 16'h0000);
      chk("rst bus_wdata", bus_wdata[0], 8'h00);
      chk("rst busy", busy[0], 1'b0);
      chk("rst cmd_ready", cmd_ready[0], 1'b0);
      chk("rst dut1 bus_valid", bus_valid[1], 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("cmd_ready after release", cmd_ready[0], 1'b1);
      @(posedge clk);
      #1;

      // Memory-mapped instance, bus_ready held high
      clear_logs(1);
      cmd_valid[1] = 1'b1;
      cmd_chip[1]  = 1'b1;
      cmd_reg[1]   = 8'h30;
      cmd_data[1]  = 8'h0F;
      @(negedge clk);
      chk("dut1 cmd_ready 1", cmd_ready[1], 1'b1);
      expect_pair(1, 1'b1, 8'h30, 8'h0F);
      @(posedge clk);
      #1;
      cmd_chip[1] = 1'b0;
      cmd_reg[1]  = 8'h31;
      cmd_data[1] = 8'hF0;
      @(negedge clk);
      chk("dut1 cmd_ready 2", cmd_ready[1], 1'b1);
      expect_pair(1, 1'b0, 8'h31, 8'hF0);
      @(posedge clk);
      #1 cmd_valid[1] = 1'b0;
      wait_idle(1, 500, "dut1 idle timeout");
      chk("dut1 handshake count", hs_log[1].size(), 4);
      if (hs_log[1].size() >= 1 && rise_log[1].size() >= 2)
         chk("dut1 addr-to-data wait", rise_log[1][1] - hs_log[1][0], 8);
      chk("dut1 scoreboard drained", exp_q[1].size(), 0);

      // Single write, ready 5 cycles after each valid
      clear_logs(0);
      resp_mode = 2;
      push0(1'b0, 8'h10, 8'h55, 1'b1, 1'b1);
      cmd_valid[0] = 1'b0;
      wait_idle(0, 5000, "single write idle timeout");
      chk("single handshake count", hs_log[0].size(), 2);
      if (hs_log[0].size() >= 1 && rise_log[0].size() >= 2) begin
         chk("addr handshake latency", hs_log[0][0] - rise_log[0][0], 5);
         chk("data valid after addr handshake", rise_log[0][1] - hs_log[0][0], 288);
      end
      chk("single scoreboard drained", exp_q[0].size(), 0);

      // FIFO full: one command stalled in ADDR, then 5 pushes
      clear_logs(0);
      resp_mode = 0;
      push0(1'b1, 8'h40, 8'h01, 1'b1, 1'b1);
      cmd_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++)
         push0(logic'(i[0]), 8'(8'h50 + i), 8'(8'hA0 + i), logic'(i < 4), logic'(i < 4));
      cmd_valid[0] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("stall no handshake", hs_log[0].size(), 0);
      chk("stall valid held", bus_valid[0], 1'b1);
      chk("stall cmd_ready", cmd_ready[0], 1'b0);
      @(posedge clk);
      #1 resp_mode = 2;
      wait_idle(0, 15000, "full fifo idle timeout");
      chk("full fifo handshake count", hs_log[0].size(), 10);
      chk("full fifo scoreboard drained", exp_q[0].size(), 0);

      // Two queued commands, ready held high
      clear_logs(0);
      resp_mode = 1;
      push0(1'b0, 8'h20, 8'h11, 1'b1, 1'b1);
      push0(1'b1, 8'h21, 8'h22, 1'b1, 1'b1);
      cmd_valid[0] = 1'b0;
      n = 0;
      begin
         int busy_drops = 0;
         while (hs_log[0].size() < 4 && n < 6000) begin
            @(negedge clk);
            n++;
            if (busy[0] !== 1'b1) busy_drops++;
         end
         chk("two cmd handshake count", hs_log[0].size(), 4);
         chk("two cmd busy drops", busy_drops, 0);
      end
      if (hs_log[0].size() >= 2 && rise_log[0].size() >= 3) begin
         chk("ready-high first-cycle handshake", hs_log[0][0] - rise_log[0][0], 1);
         chk("second cmd start after data wait", rise_log[0][2] - hs_log[0][1], 2017);
      end
      wait_idle(0, 3000, "two cmd idle timeout");
      chk("two cmd scoreboard drained", exp_q[0].size(), 0);

      // Reset while stalled in the data phase
      clear_logs(0);
      resp_mode = 2;
      push0(1'b1, 8'h20, 8'hAA, 1'b1, 1'b0);
      exp_q[0].push_back('{addr: 16'h007A, wdata: 8'h20});
      cmd_valid[0] = 1'b0;
      n = 0;
      while (hs_log[0].size() < 1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      resp_mode = 0;
      chk("abort addr handshake", hs_log[0].size(), 1);
      @(posedge clk);
      #1;
      push0(1'b0, 8'h01, 8'h02, 1'b1, 1'b0);
      cmd_valid[0] = 1'b0;
      n = 0;
      while (bus_valid[0] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("abort data address", bus_address[0], 16'h007B);
      chk("abort data wdata", bus_wdata[0], 8'hAA);
      chk("abort busy before reset", busy[0], 1'b1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort valid at reset edge", bus_valid[0], 1'b0);
      chk("abort cmd_ready in reset", cmd_ready[0], 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort busy after release", busy[0], 1'b0);
      chk("abort cmd_ready after release", cmd_ready[0], 1'b1);
      repeat (30) @(negedge clk);
      chk("abort no further handshakes", hs_log[0].size(), 1);
      chk("abort valid stays low", bus_valid[0], 1'b0);
      chk("abort scoreboard drained", exp_q[0].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
